// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, error codes
// and frame layout.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_SUM  = 2'b10
    } err_t;

    // Number of length bytes that precede the data payload in a frame.
    localparam int HDR_LEN = 2;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and word write port out of the program loader.
// The slave modport is the loader's view; master is the source/memory side.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wd
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wd
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs four stream bytes, least significant first, into a 32-bit word and
// raises word_valid_o for one cycle after the fourth byte lands.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  idx_q;
    logic [23:0] shift_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    // Finished words live in a separate register so mem_wd does not move
    // while the next word is being collected.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q        <= 2'd0;
            shift_q      <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                idx_q   <= 2'd0;
                shift_q <= 24'd0;
                word_q  <= 32'd0;
            end else if (byte_valid_i) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q       <= {byte_i, shift_q};
                    word_valid_q <= 1'b1;
                end else begin
                    shift_q <= {byte_i, shift_q[23:8]};
                end
            end
        end
    end

    assign last_byte_o  = (idx_q == 2'd3);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;
endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: length header, little-endian words, checksum.
// Writes words to the core's memory and releases cpu_reset on a verified frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    prog_loader_if.slave       bus,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic [1:0]         error
);
    state_t      state_q, state_d;
    err_t        err_q, err_d;
    logic [15:0] n_q, n_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] addr_q, addr_d;

    logic        xfer;
    logic        asm_clear;
    logic        asm_byte;
    logic        asm_last;
    logic [15:0] n_full;
    logic [7:0]  sum_final;

    assign busy         = (state_q == LEN0) || (state_q == LEN1) ||
                          (state_q == DATA) || (state_q == CHECK);
    assign bus.in_ready = busy;
    assign xfer         = bus.in_valid && busy;
    assign n_full       = {bus.in_data, n_q[7:0]};
    assign sum_final    = sum_q + bus.in_data;

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_byte),
        .byte_i       (bus.in_data),
        .last_byte_o  (asm_last),
        .word_valid_o (bus.mem_we),
        .word_o       (bus.mem_wd)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        n_d       = n_q;
        wcnt_d    = wcnt_q;
        sum_d     = sum_q;
        addr_d    = addr_q;
        asm_clear = 1'b0;
        asm_byte  = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = LEN0;
                    err_d     = ERR_NONE;
                    wcnt_d    = 16'd0;
                    sum_d     = 8'd0;
                    asm_clear = 1'b1;
                end
            end
            LEN0: begin
                if (xfer) begin
                    n_d     = {8'd0, bus.in_data};
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    n_d = n_full;
                    if ({16'd0, n_full} > 32'(MEM_WORDS)) begin
                        state_d = ERROR;
                        err_d   = ERR_LEN;
                    end else if (n_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_byte = 1'b1;
                    sum_d    = sum_final;
                    // Address is registered on the same edge the assembler
                    // latches the word, so both appear together with mem_we.
                    if (asm_last) begin
                        addr_d = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
                        wcnt_d = wcnt_q + 16'd1;
                        if (wcnt_q == n_q - 16'd1) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (sum_final == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_SUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            n_q     <= 16'd0;
            wcnt_q  <= 16'd0;
            sum_q   <= 8'd0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.mem_addr = addr_q;
    assign cpu_reset    = (state_q != DONE);
    assign done         = (state_q == DONE);
    assign error        = err_q;
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the instruction or data memory of the single-cycle RISC-V core before the core runs. It is the write end of the memory read port the core fetches from. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues word writes. It holds the core in reset until a frame has loaded and its checksum has verified.

## Interface
Parameters:
- MEM_WORDS, 64: capacity of the target memory in words. A frame with a word count N > MEM_WORDS is rejected.
- BASE_ADDR, 32'h0: byte address of word 0. Must be word aligned.

Ports:
- clk  input  1  system clock. All state changes on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- start  input  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  word write strobe, one cycle per word.
- mem_addr  output  32  byte address, word aligned. The target memory indexes it with bits [31:2].
- mem_wd  output  32  write data.
- cpu_reset  output  1  active-high reset to the core.
- busy  output  1  a load is in progress.
- done  output  1  the last load succeeded.
- error  output  2  00 none, 01 length overflow, 10 checksum mismatch.

## Operation
- Frame format, in order:
  - byte 0: N[7:0].
  - byte 1: N[15:8].
  - 4·N data bytes, least significant byte of each word first.
  - one checksum byte C.
  - Valid frame: (sum of all data bytes + C) mod 256 == 0. Length bytes are excluded from the sum.
- A byte transfers on a rising edge where in_valid & in_ready are both 1. in_data is ignored otherwise.
- States and transitions:
  - IDLE → LEN0 on start.
  - LEN0 → LEN1 on transfer.
  - LEN1 → ERROR(01) if N > MEM_WORDS.
  - LEN1 → CHECK if N == 0.
  - LEN1 → DATA otherwise.
  - DATA: byte index 0..3 cycles. After byte 3 of word k:
    - register mem_wd = {b3,b2,b1,b0} and mem_addr = BASE_ADDR + 4k;
    - pulse mem_we;
    - after word N-1, → CHECK.
  - CHECK → DONE if the checksum is valid, → ERROR(10) otherwise.
  - DONE / ERROR → LEN0 on start.
- in_ready = 1 in LEN0, LEN1, DATA and CHECK. It is 0 in IDLE, DONE and ERROR.
- cpu_reset:
  - 1 in every state except DONE;
  - a new start from DONE reasserts it.
- busy = 1 in LEN0, LEN1, DATA and CHECK.
- error holds its code until the next start, which clears it to 00.
- start is ignored while busy.
- Word counter and byte index are 16 and 2 bits. They are cleared when LEN0 is entered.
- Checksum accumulator is 8 bits, wraps mod 256, and is cleared when LEN0 is entered.
- Reset values:
  - state IDLE;
  - in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wd 0;
  - cpu_reset 1, busy 0, done 0, error 00.
- Reset mid-load:
  - return to IDLE next edge;
  - any pending write is dropped (mem_we 0);
  - words already written stay in memory;
  - cpu_reset stays 1.

## Timing
- The cycle after the edge that transfers data byte 3: mem_we = 1 for exactly one cycle, with mem_addr and mem_wd stable.
- in_ready stays 1 during that write cycle. The next byte may transfer while the write is in flight.
- Checksum transfer edge → next cycle: done = 1, cpu_reset = 0, busy = 0.
  - Or, on failure: error = 10, cpu_reset = 1.
- LEN1 transfer edge with N > MEM_WORDS → next cycle: error = 01.
  - No mem_we in that frame.
  - Remaining stream bytes are not accepted.
- Minimum load time at full throughput: 4N + 3 transfers + 1 cycle.
- in_valid may drop at any point; the state is held with no timeout.
- start and a transfer in the same cycle from DONE: start wins. The byte is not accepted, because in_ready = 0 in DONE.

## Structure
- Package prog_loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR);
  - error codes ERR_NONE, ERR_LEN, ERR_SUM;
  - the frame header length constant (2).
- One sub-module: word_assembler.
  - Contents: 2-bit byte index, 32-bit little-endian shift/insert register, word_valid pulse.
  - Cleared by the top level on LEN0 entry.
- The top level holds the FSM, word counter, address generation, checksum accumulator and status outputs.

## Test plan
- Reset then start, frame N=2, words 32'h00500113, 32'h00C00193, correct C:
  - mem_we pulses at 32'h0 and 32'h4 with those values;
  - done = 1, cpu_reset falls one cycle after the C transfer.
- Same frame with C off by one: no change to the writes; error = 10, cpu_reset stays 1, done = 0.
- N=65 with MEM_WORDS=64: error = 01 one cycle after byte 1; zero mem_we pulses; in_ready = 0 afterwards.
- N=0 followed by C=8'h00: done = 1, no writes.
- Random in_valid gaps, 50% duty, over a 16-word frame: identical write sequence to the gap-free run.
- Reset low after 5 data bytes of N=3: IDLE the next cycle, no further mem_we, cpu_reset = 1. A following start and full frame loads correctly from word 0.
